umi_arbiter: RTL and testbench

- Round-robin arbiter that shares one UMI output channel among N requesters.
- Decodes the 32-bit command in each header beat: opcode = cmd[7:0], size = cmd[11:8], read = opcode[3], atomic = opcode[3:0]==4'b1001, invalid = opcode==0.
- Locks the grant for the full packet so that multi-beat writes and atomics are never interleaved.
- Sits between requester agents and the shared UMI fabric port; drops invalid commands.

---
 rtl/umi_arbiter.sv | 85 ++++++++
 tb/tb_umi_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/umi_arbiter.sv
// umi_arbiter: round-robin UMI channel arbiter with per-packet grant lock
module umi_arbiter #(
  parameter int N  = 4,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*DW-1:0] umi_in_packet,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [DW-1:0]   umi_out_packet,
  input  logic            umi_out_ready,
  output logic [N-1:0]    grant,
  output logic            err_invalid,
  input  logic            err_clear
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, HOLD, BURST} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] ptr, sel, pick, owner;
  logic [3:0] cnt, extra;
  logic [7:0] opcode;
  logic [N-1:0] onehot;
  logic any, invalid, drop, xfer, idle_empty;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] x);
    return (x == PW'(N - 1)) ? '0 : x + 1'b1;
  endfunction
  // scan downward so the requester closest to ptr is the last to overwrite pick
  always_comb begin
    pick = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (umi_in_valid[j]) begin
        pick = j[PW-1:0];
        any = 1'b1;
      end
    end
  end
  always_comb begin
    owner = (state == IDLE) ? pick : sel;
    umi_out_packet = umi_in_packet[owner*DW +: DW];
    opcode = umi_out_packet[7:0];
    invalid = (opcode == 8'h00);
    extra = (!opcode[3] || opcode[3:0] == 4'b1001) ? umi_out_packet[11:8] : 4'd0;
    idle_empty = (state == IDLE) && !any;
    drop = (state == IDLE) && any && invalid;
    onehot = {{(N-1){1'b0}}, 1'b1} << owner;
    umi_out_valid = !reset && ((state == IDLE) ? any && !invalid : umi_in_valid[owner]);
    xfer = umi_out_valid && umi_out_ready;
    umi_in_ready = (reset || idle_empty) ? '0 : ((drop || umi_out_ready) ? onehot : '0);
    grant = (reset || idle_empty) ? '0 : onehot;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = (!any || invalid) ? IDLE : !umi_out_ready ? HOLD : (extra != 0) ? BURST : IDLE;
      HOLD:  state_nxt = !xfer ? HOLD : (extra != 0) ? BURST : IDLE;
      BURST: state_nxt = (xfer && cnt == 4'd1) ? IDLE : BURST;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      cnt <= '0;
      err_invalid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (drop) err_invalid <= 1'b1;
      else if (err_clear) err_invalid <= 1'b0;
      if (state == IDLE && any) begin
        if (!invalid) sel <= pick;
        if (drop || umi_out_ready) ptr <= inc(pick);
      end
      if (state == HOLD && xfer) ptr <= inc(sel);
      if (state != BURST && xfer) cnt <= extra;
      else if (state == BURST && xfer) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_umi_arbiter.sv
// tb_umi_arbiter: directed checks of arbitration, locking, drops and reset
module tb_umi_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] umi_in_valid;
  logic [255:0] umi_in_packet;
  logic [3:0] umi_in_ready;
  logic umi_out_valid;
  logic [63:0] umi_out_packet;
  logic umi_out_ready;
  logic [3:0] grant;
  logic err_invalid;
  logic err_clear;
  int n_checks = 0;
  int n_fail = 0;

  umi_arbiter #(.N(4), .DW(64)) dut (
    .clk(clk), .reset(reset),
    .umi_in_valid(umi_in_valid), .umi_in_packet(umi_in_packet), .umi_in_ready(umi_in_ready),
    .umi_out_valid(umi_out_valid), .umi_out_packet(umi_out_packet), .umi_out_ready(umi_out_ready),
    .grant(grant), .err_invalid(err_invalid), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [63:0] p);
    umi_in_packet[i*64 +: 64] = p;
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] op, input logic [3:0] size, input logic [31:0] id);
    return {id, 20'h0, size, op};
  endfunction

  initial begin
    reset = 1'b1; umi_out_ready = 1'b1; err_clear = 1'b0; umi_in_packet = '0;
    for (int i = 0; i < 4; i++) put(i, hdr(8'h08, 4'd0, 32'h0));
    umi_in_valid = 4'b1111;
    step;
    check("rst_grant", grant, 4'b0000);
    check("rst_out_valid", umi_out_valid, 1'b0);
    check("rst_in_ready", umi_in_ready, 4'b0000);
    check("rst_err", err_invalid, 1'b0);
    reset = 1'b0; umi_in_valid = 4'b0000;
    step;
    // two single-beat reads back to back
    put(0, hdr(8'h08, 4'd0, 32'h10)); put(2, hdr(8'h08, 4'd0, 32'h12));
    umi_in_valid = 4'b0101; #1;
    check("rr_grant0", grant, 4'b0001);
    check("rr_pkt0", umi_out_packet, hdr(8'h08, 4'd0, 32'h10));
    check("rr_ready0", umi_in_ready, 4'b0001);
    step;
    umi_in_valid = 4'b0100; #1;
    check("rr_grant2", grant, 4'b0100);
    check("rr_pkt2", umi_out_packet, hdr(8'h08, 4'd0, 32'h12));
    step;
    put(3, hdr(8'h08, 4'd0, 32'h13));
    umi_in_valid = 4'b1001; #1;
    check("rr_ptr3", grant, 4'b1000);
    step;
    umi_in_valid = 4'b0000;
    step;
    // 4-beat write from req1 while req0 waits
    put(1, hdr(8'h01, 4'd3, 32'h21));
    umi_in_valid = 4'b0010; #1;
    check("wr_hdr_grant", grant, 4'b0010);
    step;
    put(0, hdr(8'h08, 4'd0, 32'h20));
    umi_in_valid = 4'b0011;
    for (int b = 1; b <= 3; b++) begin
      put(1, 64'hD000 + 64'(b)); #1;
      check("wr_beat_grant", grant, 4'b0010);
      check("wr_beat_pkt", umi_out_packet, 64'hD000 + 64'(b));
      check("wr_beat_ready", umi_in_ready, 4'b0010);
      step;
    end
    umi_in_valid = 4'b0001; #1;
    check("wr_after_grant", grant, 4'b0001);
    step;
    umi_in_valid = 4'b0000;
    step;
    // stalled header holds grant against a higher-priority newcomer
    umi_out_ready = 1'b0;
    put(2, hdr(8'h08, 4'd0, 32'h32));
    umi_in_valid = 4'b0100; #1;
    check("hold_grant", grant, 4'b0100);
    check("hold_ready", umi_in_ready, 4'b0000);
    check("hold_valid", umi_out_valid, 1'b1);
    step;
    put(1, hdr(8'h08, 4'd0, 32'h31));
    umi_in_valid = 4'b0110; #1;
    check("hold_grant2", grant, 4'b0100);
    check("hold_pkt", umi_out_packet, hdr(8'h08, 4'd0, 32'h32));
    step;
    check("hold_grant3", grant, 4'b0100);
    step;
    umi_out_ready = 1'b1; #1;
    check("hold_xfer_ready", umi_in_ready, 4'b0100);
    check("hold_xfer_pkt", umi_out_packet, hdr(8'h08, 4'd0, 32'h32));
    step;
    umi_in_valid = 4'b0010; #1;
    check("hold_next_grant", grant, 4'b0010);
    step;
    umi_in_valid = 4'b0000;
    step;
    // invalid header drop and set-over-clear priority
    put(3, 64'h0000_0000_0000_0500);
    umi_in_valid = 4'b1000; #1;
    check("inv_ready", umi_in_ready, 4'b1000);
    check("inv_out_valid", umi_out_valid, 1'b0);
    check("inv_err_pre", err_invalid, 1'b0);
    step;
    check("inv_err_set", err_invalid, 1'b1);
    err_clear = 1'b1; #1;
    check("inv_ready2", umi_in_ready, 4'b1000);
    step;
    err_clear = 1'b0; umi_in_valid = 4'b0000; #1;
    check("inv_err_prio", err_invalid, 1'b1);
    err_clear = 1'b1;
    step;
    err_clear = 1'b0; #1;
    check("inv_err_clr", err_invalid, 1'b0);
    // atomic with a 2-cycle bubble after the header
    put(0, hdr(8'h19, 4'd2, 32'h50)); put(1, hdr(8'h08, 4'd0, 32'h51));
    umi_in_valid = 4'b0011; #1;
    check("atm_grant", grant, 4'b0001);
    check("atm_valid", umi_out_valid, 1'b1);
    step;
    umi_in_valid = 4'b0010;
    repeat (2) begin
      #1;
      check("atm_bubble_valid", umi_out_valid, 1'b0);
      check("atm_bubble_grant", grant, 4'b0001);
      step;
    end
    umi_in_valid = 4'b0011;
    for (int b = 1; b <= 2; b++) begin
      put(0, 64'hE00 + 64'(b)); #1;
      check("atm_beat_grant", grant, 4'b0001);
      check("atm_beat_pkt", umi_out_packet, 64'hE00 + 64'(b));
      check("atm_beat_valid", umi_out_valid, 1'b1);
      step;
    end
    umi_in_valid = 4'b0010; #1;
    check("atm_release", grant, 4'b0010);
    step;
    umi_in_valid = 4'b0000;
    step;
    // reset mid-burst aborts the packet
    put(0, hdr(8'h01, 4'd5, 32'h60));
    umi_in_valid = 4'b0001; #1;
    check("rb_grant", grant, 4'b0001);
    step;
    put(0, 64'hF01); #1;
    check("rb_beat2", umi_out_packet, 64'hF01);
    step;
    reset = 1'b1; #1;
    check("rb_rst_valid", umi_out_valid, 1'b0);
    check("rb_rst_grant", grant, 4'b0000);
    step;
    reset = 1'b0;
    put(0, hdr(8'h08, 4'd0, 32'h70)); put(2, hdr(8'h08, 4'd0, 32'h72));
    umi_in_valid = 4'b0101; #1;
    check("rb_post_grant", grant, 4'b0001);
    check("rb_post_pkt", umi_out_packet, hdr(8'h08, 4'd0, 32'h70));
    step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
